// File: rtl/mul_sign_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
//   Shared definitions for the RV64M sign-control wrapper around the unsigned
//   start/done multiplier core.
//   - XLEN_DEFAULT : default operand/result width (product is 2*XLEN).
//   - F3_*         : funct3 encodings of the four multiply operations.
//   - state_t      : issue/retire FSM states.
//   - op_* helpers : per-operation signedness and half selection, so every
//                    consumer decodes funct3[1:0] the same way.
// -----------------------------------------------------------------------------
package mul_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    FIX   = 3'd3,
    OUT   = 3'd4
  } state_t;

  // rs1 is treated as signed for MULH and MULHSU.
  function automatic logic op_signed_a(input logic [1:0] op);
    return (op == F3_MULH[1:0]) || (op == F3_MULHSU[1:0]);
  endfunction

  // rs2 is treated as signed only for MULH.
  function automatic logic op_signed_b(input logic [1:0] op);
    return (op == F3_MULH[1:0]);
  endfunction

  // MUL returns the low half; every other op returns the high half.
  function automatic logic op_high_half(input logic [1:0] op);
    return (op != F3_MUL[1:0]);
  endfunction

endpackage

// File: rtl/mul_sign_ctrl_if.sv
// -----------------------------------------------------------------------------
// mul_sign_ctrl_if
//   Bundles both sides of the sign-control stage:
//   - execute side : in_valid/in_ready/funct3/rs1/rs2 (operation in),
//                    out_valid/out_ready/result (selected product half out).
//   - core side    : mul_start/mul_a/mul_b (operand magnitudes out),
//                    mul_done/mul_p (unsigned 2*XLEN product in).
//   Modports:
//   - slave  : the sign-control block itself.
//   - master : whatever surrounds it (execute stage plus multiplier core).
// -----------------------------------------------------------------------------
interface mul_sign_ctrl_if #(
  parameter int XLEN = mul_pkg::XLEN_DEFAULT
);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   rs1;
  logic [XLEN-1:0]   rs2;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   result;
  logic              mul_start;
  logic [XLEN-1:0]   mul_a;
  logic [XLEN-1:0]   mul_b;
  logic              mul_done;
  logic [2*XLEN-1:0] mul_p;

  modport slave (
    input  in_valid, funct3, rs1, rs2, out_ready, mul_done, mul_p,
    output in_ready, out_valid, result, mul_start, mul_a, mul_b
  );

  modport master (
    output in_valid, funct3, rs1, rs2, out_ready, mul_done, mul_p,
    input  in_ready, out_valid, result, mul_start, mul_a, mul_b
  );

endinterface

// File: rtl/mul_sign_ctrl_cond_neg.sv
// -----------------------------------------------------------------------------
// mul_cond_neg
//   Combinational conditional two's-complement negate of a W-bit value.
//   Ports:
//   - din  : value to (optionally) negate.
//   - neg  : 1 -> dout = -din, 0 -> dout = din.
//   - dout : result, same width as din.
//   -0 is 0 and -(2^(W-1)) is 2^(W-1) when read as unsigned, so the operand
//   magnitude path needs no special cases.
// -----------------------------------------------------------------------------
module mul_cond_neg #(
  parameter int W = 64
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  logic [W-1:0] inv;

  // Invert every bit when negating, then add neg as the +1 carry-in.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_inv
      assign inv[gi] = din[gi] ^ neg;
    end
  endgenerate

  assign dout = inv + {{(W-1){1'b0}}, neg};

endmodule

// File: rtl/mul_sign_ctrl.sv
// -----------------------------------------------------------------------------
// mul_sign_ctrl
//   Issue/retire stage around an unsigned start/done multiplier core for
//   RV64M MUL, MULH, MULHSU and MULHU.
//   Ports:
//   - clk   : clock, all state updates on the rising edge.
//   - rst_n : asynchronous active-low reset; drops any in-flight operation.
//   - bus   : mul_sign_ctrl_if.slave (execute handshake + core interface).
//   Flow: IDLE (accept, form magnitudes) -> START (one-cycle mul_start)
//         -> WAIT (capture mul_p on mul_done) -> FIX (sign-correct, select
//         half) -> OUT (hold result until out_ready) -> IDLE.
//   Optional build macro MUL_REUSE_EN: remembers the last operands, their
//   signedness and the corrected product; a matching operation skips the core
//   (IDLE -> FIX) and is answered from the stored product.
// -----------------------------------------------------------------------------
module mul_sign_ctrl
  import mul_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_sign_ctrl_if.slave bus
);

  localparam int PW = 2 * XLEN;

  state_t          state_reg;
  state_t          state_next;

  logic [1:0]      sgn_reg;      // funct3[1:0] of the operation in flight
  logic            neg_reg;      // product must be negated in FIX
  logic [XLEN-1:0] mul_a_reg;
  logic [XLEN-1:0] mul_b_reg;
  logic [PW-1:0]   p_raw_reg;    // unsigned product as delivered by the core
  logic [PW-1:0]   product_reg;  // sign-corrected product
  logic [XLEN-1:0] result_reg;

  logic            in_ready_c;
  logic            out_valid_c;
  logic            mul_start_c;

  // funct3[2] selects the divide group upstream and carries no meaning here.
  logic            unused_funct3_msb;
  assign unused_funct3_msb = bus.funct3[2];

  // ---------------------------------------------------------------------------
  // Operand magnitudes
  // ---------------------------------------------------------------------------
  logic [1:0]      sgn_in;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  assign sgn_in = bus.funct3[1:0];
  assign neg_a  = op_signed_a(sgn_in) & bus.rs1[XLEN-1];
  assign neg_b  = op_signed_b(sgn_in) & bus.rs2[XLEN-1];

  mul_cond_neg #(.W(XLEN)) u_neg_a (
    .din  (bus.rs1),
    .neg  (neg_a),
    .dout (mag_a)
  );

  mul_cond_neg #(.W(XLEN)) u_neg_b (
    .din  (bus.rs2),
    .neg  (neg_b),
    .dout (mag_b)
  );

  // ---------------------------------------------------------------------------
  // Product sign correction
  // ---------------------------------------------------------------------------
  logic [PW-1:0]   p_fixed;
  logic [PW-1:0]   fix_prod;
  logic            use_stored;

  mul_cond_neg #(.W(PW)) u_neg_p (
    .din  (p_raw_reg),
    .neg  (neg_reg),
    .dout (p_fixed)
  );

  // A reuse hit takes the already-corrected product; it must not be negated again.
  assign fix_prod = use_stored ? product_reg : p_fixed;

  logic accept;
  logic hit;

  assign accept = (state_reg == IDLE) & bus.in_valid;

  // ---------------------------------------------------------------------------
  // Optional result reuse
  // ---------------------------------------------------------------------------
`ifdef MUL_REUSE_EN
  logic [XLEN-1:0] last_rs1_reg;
  logic [XLEN-1:0] last_rs2_reg;
  logic [1:0]      last_sgn_reg;
  logic            hit_valid_reg;
  logic            hit_reg;

  // The low half of the product does not depend on signedness, so a MUL can
  // be served by any stored product of the same operands.
  assign hit = hit_valid_reg
             & (bus.rs1 == last_rs1_reg)
             & (bus.rs2 == last_rs2_reg)
             & ((sgn_in == last_sgn_reg) | (sgn_in == F3_MUL[1:0]));

  assign use_stored = hit_reg;

  // product_reg doubles as the stored product: it is only rewritten in FIX,
  // and a hit rewrites it with its own value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rs1_reg  <= '0;
      last_rs2_reg  <= '0;
      last_sgn_reg  <= '0;
      hit_valid_reg <= 1'b0;
      hit_reg       <= 1'b0;
    end else begin
      if (accept) begin
        hit_reg <= hit;
      end
      if (accept && !hit) begin
        last_rs1_reg  <= bus.rs1;
        last_rs2_reg  <= bus.rs2;
        last_sgn_reg  <= sgn_in;
        hit_valid_reg <= 1'b0;
      end
      if ((state_reg == FIX) && !hit_reg) begin
        hit_valid_reg <= 1'b1;
      end
    end
  end
`else
  assign hit        = 1'b0;
  assign use_stored = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    mul_start_c = 1'b0;
    unique case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_next = hit ? FIX : START;
        end
      end
      START: begin
        mul_start_c = 1'b1;
        state_next  = WAIT;
      end
      WAIT: begin
        // mul_done is only meaningful here; a stale pulse elsewhere is dropped.
        if (bus.mul_done) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = OUT;
      end
      OUT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_reg     <= '0;
      neg_reg     <= 1'b0;
      mul_a_reg   <= '0;
      mul_b_reg   <= '0;
      p_raw_reg   <= '0;
      product_reg <= '0;
      result_reg  <= '0;
    end else begin
      if (accept) begin
        sgn_reg <= sgn_in;
      end
      // Core operands only move for operations that actually use the core,
      // so they stay stable from START until after mul_done.
      if (accept && !hit) begin
        neg_reg   <= neg_a ^ neg_b;
        mul_a_reg <= mag_a;
        mul_b_reg <= mag_b;
      end
      if ((state_reg == WAIT) && bus.mul_done) begin
        p_raw_reg <= bus.mul_p;
      end
      if (state_reg == FIX) begin
        product_reg <= fix_prod;
        result_reg  <= op_high_half(sgn_reg) ? fix_prod[PW-1:XLEN]
                                             : fix_prod[XLEN-1:0];
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.mul_start = mul_start_c;
  assign bus.mul_a     = mul_a_reg;
  assign bus.mul_b     = mul_b_reg;
  assign bus.result    = result_reg;

endmodule

// File: tb/tb_mul_sign_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_sign_ctrl
//   Drives mul_sign_ctrl through its interface, with a behavioural stub of the
//   unsigned multiplier core (programmable latency). Expected results are
//   derived from the RV64M instruction definitions (sign/zero extend to 128
//   bits, multiply, pick a half) and queued at issue; a monitor compares them
//   when the DUT presents out_valid. Builds with or without MUL_REUSE_EN.
// -----------------------------------------------------------------------------
module tb_mul_sign_ctrl;
  import mul_pkg::*;

  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mul_sign_ctrl_if #(.XLEN(XLEN)) bus ();

  mul_sign_ctrl #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] res;
    int          due;
    int          stall;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
  } core_t;

  exp_t  exp_q[$];
  core_t core_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int core_lat = 1;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef MUL_REUSE_EN
  bit          last_valid = 1'b0;
  logic [63:0] last_a = '0;
  logic [63:0] last_b = '0;
  logic [1:0]  last_sgn = '0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Architectural result: extend each operand to 128 bits according to the
  // instruction's signedness, multiply modulo 2^128, return the chosen half.
  function automatic logic [63:0] ref_result(input logic [2:0] f3, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [127:0] ea;
    logic [127:0] eb;
    logic [127:0] p;
    ea = {64'b0, a};
    eb = {64'b0, b};
    case (f3[1:0])
      2'b01: begin   // MULH: signed x signed
        if (a[63]) ea[127:64] = '1;
        if (b[63]) eb[127:64] = '1;
      end
      2'b10: begin   // MULHSU: signed x unsigned
        if (a[63]) ea[127:64] = '1;
      end
      default: ;     // MUL, MULHU: unsigned
    endcase
    p = ea * eb;
    return (f3[1:0] == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  function automatic logic [63:0] magnitude(input logic [63:0] x, input bit is_signed);
    return (is_signed && x[63]) ? (64'd0 - x) : x;
  endfunction

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Stub multiplier core: on mul_start, checks operands and returns the
  // unsigned product with mul_done after core_lat cycles.
  // ---------------------------------------------------------------------------
  initial begin : core_stub
    int           cnt;
    logic [127:0] prod;
    core_t        c;
    cnt = 0;
    prod = '0;
    bus.mul_done = 1'b0;
    bus.mul_p = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mul_done = 1'b0;
      bus.mul_p = {$urandom, $urandom, $urandom, $urandom};
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.mul_done = 1'b1;
          bus.mul_p = prod;
        end
      end
      if (bus.mul_start === 1'b1) begin
        if (core_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mul_start: got a pulse at cycle %0d, required none", cyc);
        end else begin
          c = core_q.pop_front();
          chk("mul_a", bus.mul_a, c.a);
          chk("mul_b", bus.mul_b, c.b);
        end
        prod = {64'b0, bus.mul_a} * {64'b0, bus.mul_b};
        cnt = core_lat;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / consumer: latency on first out_valid, hold under backpressure,
  // result on the handshake.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    bit          ov_prev;
    bit          stalled_prev;
    logic [63:0] res_prev;
    int          stall_left;
    exp_t        e;
    ov_prev = 1'b0;
    stalled_prev = 1'b0;
    res_prev = '0;
    stall_left = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stalled_prev) begin
        chk("hold out_valid", 64'(bus.out_valid), 64'd1);
        chk("hold result", bus.result, res_prev);
        chk("hold in_ready", 64'(bus.in_ready), 64'd0);
      end
      stalled_prev = 1'b0;
      if (bus.out_valid === 1'b1 && !ov_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_valid: got 1 at cycle %0d, required 0 (nothing outstanding)", cyc);
        end else begin
          chk_int("latency", cyc, exp_q[0].due);
          stall_left = exp_q[0].stall;
        end
      end
      if (bus.out_valid === 1'b1) begin
        bus.out_ready = (stall_left == 0);
        if (stall_left > 0) begin
          stall_left--;
          stalled_prev = 1'b1;
          res_prev = bus.result;
        end else if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("result", bus.result, e.res);
          $display("cycle %0d: f3=%0d rs1=%h rs2=%h result=%h", cyc, e.f3, e.a, e.b, bus.result);
        end
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      ov_prev = (bus.out_valid === 1'b1) && !bus.out_ready;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                       input int lat, input int stall);
    exp_t  e;
    core_t c;
    int    guard;
    bit    hit;
    bus.funct3 = f3;
    bus.rs1 = a;
    bus.rs2 = b;
    bus.in_valid = 1'b1;
    core_lat = lat;
    guard = 0;
    while (bus.in_ready !== 1'b1) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 400) begin
        checks++;
        errors++;
        $display("FAIL in_ready: got 0 for %0d cycles, required 1", guard);
        bus.in_valid = 1'b0;
        return;
      end
    end
    hit = 1'b0;
`ifdef MUL_REUSE_EN
    hit = last_valid && (a == last_a) && (b == last_b)
          && ((f3[1:0] == last_sgn) || (f3[1:0] == 2'b00));
    if (!hit) begin
      last_valid = 1'b1;
      last_a = a;
      last_b = b;
      last_sgn = f3[1:0];
    end
`endif
    e.res = ref_result(f3, a, b);
    e.due = cyc + (hit ? 2 : 3 + lat);
    e.stall = stall;
    e.f3 = f3;
    e.a = a;
    e.b = b;
    exp_q.push_back(e);
    if (!hit) begin
      c.a = magnitude(a, (f3[1:0] == 2'b01) || (f3[1:0] == 2'b10));
      c.b = magnitude(b, f3[1:0] == 2'b01);
      core_q.push_back(c);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.rs1 = {$urandom, $urandom};
    bus.rs2 = {$urandom, $urandom};
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 400) begin
        checks++;
        errors++;
        $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
        exp_q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, " mul_start"}, 64'(bus.mul_start), 64'd0);
    chk({tag, " mul_a"}, bus.mul_a, 64'd0);
    chk({tag, " mul_b"}, bus.mul_b, 64'd0);
    chk({tag, " result"}, bus.result, 64'd0);
  endtask

  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    core_q.delete();
`ifdef MUL_REUSE_EN
    last_valid = 1'b0;
`endif
    #1;
    check_reset_outputs("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.funct3 = 3'b000;
    bus.rs1 = '0;
    bus.rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed corner cases
    issue(F3_MUL,    64'd3, 64'd5, 3, 0);
    issue(F3_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    issue(F3_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 17, 0);
    issue(F3_MULHSU, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 2, 0);
    issue(F3_MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4, 0);
    issue(F3_MUL,    64'h1234, 64'h10, 2, 5);
    issue(F3_MULH,   64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1, 0);
    issue(3'b101,    64'hFFFF_FFFF_FFFF_FFF9, 64'd9, 3, 0);
    issue(F3_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    drain();

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(),
            $urandom_range(1, 20), $urandom_range(0, 3));
    end
    drain();

    // Reset while waiting on the core; the late mul_done must be ignored.
    issue(F3_MUL, 64'd9, 64'd11, 17, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    pulse_reset();
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("idle after late done in_ready", 64'(bus.in_ready), 64'd1);
    chk("idle after late done out_valid", 64'(bus.out_valid), 64'd0);
    issue(F3_MUL, 64'd7, 64'd6, 5, 0);
    drain();

`ifdef MUL_REUSE_EN
    // MUL after MULH on the same operands is served without the core.
    issue(F3_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 4, 0);
    issue(F3_MUL,  64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 4, 0);
    drain();
    pulse_reset();
    issue(F3_MUL,  64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 3, 0);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_sign_ctrl.md
Name: mul_sign_ctrl

Overview:
- Issue/retire stage wrapped around the unsigned start/done multiplier core for RV64M MUL, MULH, MULHSU and MULHU.
- Upstream side: accepts an operation from the execute stage, converts signed operands to magnitudes, and pulses the core's start.
- Downstream side: waits for the core's done, captures the 2*XLEN product, applies sign correction, and returns the selected XLEN half to execute under a valid/ready handshake.

Parameters:
- XLEN, 64, operand and result width; the product is 2*XLEN.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation.
- funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU. Bit 2 is ignored.
- rs1  in  XLEN  multiplicand.
- rs2  in  XLEN  multiplier.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  selected product half.
- mul_start  out  1  one-cycle start pulse to the core.
- mul_a  out  XLEN  magnitude of rs1 to the core.
- mul_b  out  XLEN  magnitude of rs2 to the core.
- mul_done  in  1  one-cycle core completion pulse.
- mul_p  in  2*XLEN  core product, valid in the mul_done cycle.

Behaviour:
- Reset values: state IDLE, in_ready=1, out_valid=0, mul_start=0, mul_a=0, mul_b=0, result=0, product register=0.
- FSM: IDLE -> START -> WAIT -> FIX -> OUT -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, register rs1, rs2 and funct3.
  - Signedness: sa = (funct3[1:0] is 01 or 10); sb = (funct3[1:0] == 01).
  - neg_a = sa & rs1[XLEN-1]; neg_b = sb & rs2[XLEN-1].
  - Register mul_a = neg_a ? -rs1 : rs1, and mul_b likewise from rs2. The magnitude of -2^(XLEN-1) is 2^(XLEN-1), which fits in XLEN unsigned bits.
  - Register neg = neg_a ^ neg_b.
- START: mul_start=1 for exactly one cycle. mul_a and mul_b hold stable from START until the cycle after mul_done.
- WAIT: on mul_done, capture mul_p. mul_done is sampled only in WAIT and ignored in every other state; this covers a stale done arriving after reset.
- FIX: product register <= neg ? (~p + 1) : p, over the full 2*XLEN bits. result <= funct3[1:0]==00 ? low half : high half.
- OUT:
  - out_valid=1; result is stable until out_valid & out_ready.
  - On the handshake, go to IDLE.
  - out_ready held low stalls indefinitely.
  - in_ready is 0 in every state except IDLE, so there is no overlap between operations.
- Latency: accept at cycle T, mul_start at T+1, mul_done at T+1+L (core latency L >= 1), out_valid at T+3+L.
- Zero operands: the negation path yields 0, with no special casing.
- Asynchronous reset mid-operation: immediately returns to IDLE with all outputs at their reset values. The in-flight operation is dropped.

Optional Feature:
- Macro MUL_REUSE_EN.
- When defined:
  - Keeps last_rs1, last_rs2, last_sgn (funct3[1:0]), the final corrected 2*XLEN product, and a hit_valid bit (cleared by reset).
  - Hit condition: in IDLE, rs1/rs2 equal the last values AND (funct3[1:0]==last_sgn OR new op is MUL).
  - On a hit, skip START and WAIT: go IDLE -> FIX, and FIX selects the stored product without negating. Hit latency: out_valid at T+2.
  - mul_start is never pulsed on a hit.
- When undefined: every operation goes through the core, and there is no extra storage.

Decomposition:
- Package mul_pkg holds:
  - XLEN default;
  - funct3 constants F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU;
  - FSM state enum (IDLE, START, WAIT, FIX, OUT).
- Sub-module mul_cond_neg: parameterised-width combinational conditional two's-complement negate. Instantiated for the operand magnitudes (XLEN) and the product fix (2*XLEN).

Test Plan:
- MUL: rs1=3, rs2=5 -> mul_a=3, mul_b=5, single mul_start pulse, result=15.
- MULH: rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> mul_a=mul_b=1, result=0. MULHU with the same operands -> result=0xFFFF_FFFF_FFFF_FFFE.
- MULHSU: rs1=-2, rs2=3 -> product -6, result=0xFFFF_FFFF_FFFF_FFFF. MULH: rs1=rs2=0x8000_0000_0000_0000 -> result=0x4000_0000_0000_0000.
- Backpressure: out_ready low for 5 cycles after out_valid -> out_valid, result and in_ready=0 all held. Also a stub core with L=1 and L=17 -> out_valid exactly at T+3+L.
- Reset: rst_n low during WAIT -> all outputs at reset values immediately. A late mul_done after reset is ignored, and the next op (7*6=42) completes correctly.
- MUL_REUSE_EN: MULH(-1,5), then MUL(-1,5) -> second op has no mul_start, result=0xFFFF_FFFF_FFFF_FFFB at T+2. A reset then clears the hit, so the same op restarts the core.
